// File: rtl/sipo_pkg.sv
// sipo_pkg: shared types for the LSB-first serial receiver.
// Holds the FSM state enum, default width and counter type.
package sipo_pkg;

  localparam int SIPO_DW = 4;
  localparam int SIPO_CW = $clog2(SIPO_DW);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    SHIFT  = 2'd1,
    PARITY = 2'd2
  } state_e;

  typedef logic [SIPO_CW-1:0] cnt_t;

endpackage

// File: rtl/sipo_lsb.sv
// sipo_lsb: enable-gated right-shift register, serial in at MSB.
// Ports: clk, rst (async low), en, din -> q (current), nxt (post-shift).
module sipo_lsb #(
  parameter int DW = 4
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          en,
  input  logic          din,
  output logic [DW-1:0] q,
  output logic [DW-1:0] nxt
);

  assign nxt = {din, q[DW-1:1]};

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      q <= '0;
    end else if (en) begin
      q <= nxt;
    end
  end

endmodule

// File: rtl/sipo_lsb_rx.sv
// sipo_lsb_rx: LSB-first serial receiver, DW bits then optional parity.
// Ports: clk, rst (async low), enb, start, inp -> out, valid, busy,
// par_err. Define SIPO_PARITY_EN to add a trailing even-parity bit.
module sipo_lsb_rx
  import sipo_pkg::*;
#(
  parameter int DW = SIPO_DW
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          enb,
  input  logic          start,
  input  logic          inp,
  output logic [DW-1:0] out,
  output logic          valid,
  output logic          busy,
  output logic          par_err
);

  localparam int CW = $clog2(DW);
  localparam logic [CW-1:0] LAST = CW'(DW-1);

  state_e state;
  state_e state_nxt;

  logic [CW-1:0] cnt;
  logic [CW-1:0] cnt_nxt;
  logic          sh_en;
  logic          done;
  logic [DW-1:0] sr;
  logic [DW-1:0] sr_nxt;

  sipo_lsb #(
    .DW(DW)
  ) u_sr (
    .clk (clk),
    .rst (rst),
    .en  (sh_en),
    .din (inp),
    .q   (sr),
    .nxt (sr_nxt)
  );

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state <= IDLE;
      cnt   <= '0;
    end else begin
      state <= state_nxt;
      cnt   <= cnt_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    cnt_nxt   = cnt;
    sh_en     = 1'b0;
    done      = 1'b0;
    unique case (state)
      IDLE: begin
        if (enb && start) begin
          sh_en     = 1'b1;
          cnt_nxt   = CW'(1);
          state_nxt = SHIFT;
        end
      end
      SHIFT: begin
        if (enb) begin
          sh_en = 1'b1;
          if (cnt == LAST) begin
            cnt_nxt = '0;
`ifdef SIPO_PARITY_EN
            state_nxt = PARITY;
`else
            state_nxt = IDLE;
            done      = 1'b1;
`endif
          end else begin
            cnt_nxt = cnt + 1'b1;
          end
        end
      end
      PARITY: begin
        if (enb) begin
          state_nxt = IDLE;
          done      = 1'b1;
        end
      end
      default: begin
        state_nxt = IDLE;
        cnt_nxt   = '0;
      end
    endcase
  end

  assign busy = (state != IDLE);

  // In the parity build the data is already complete in sr when the
  // parity bit arrives; otherwise the last bit is still being shifted.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      out   <= '0;
      valid <= 1'b0;
    end else begin
      valid <= done;
      if (done) begin
`ifdef SIPO_PARITY_EN
        out <= sr;
`else
        out <= sr_nxt;
`endif
      end
    end
  end

`ifdef SIPO_PARITY_EN
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      par_err <= 1'b0;
    end else if (done) begin
      par_err <= (^sr) ^ inp;
    end
  end
`else
  assign par_err = 1'b0;
`endif

endmodule

// File: tb/tb_sipo_lsb_rx.sv
// tb_sipo_lsb_rx: directed frames against a bit-queue model.
// Compares every cycle plus literal pins on key points.
module tb_sipo_lsb_rx;

  localparam int DW = 4;
`ifdef SIPO_PARITY_EN
  localparam int PB = 1;
`else
  localparam int PB = 0;
`endif

  logic clk = 1'b0;
  logic rst = 1'b0;
  logic enb = 1'b0;
  logic start = 1'b0;
  logic inp = 1'b0;
  logic [DW-1:0] out;
  logic valid;
  logic busy;
  logic par_err;

  int checks = 0;
  int failures = 0;
  int ncyc = 0;
  bit run = 1'b0;

  always #5 clk = ~clk;

  sipo_lsb_rx #(
    .DW(DW)
  ) dut (
    .clk     (clk),
    .rst     (rst),
    .enb     (enb),
    .start   (start),
    .inp     (inp),
    .out     (out),
    .valid   (valid),
    .busy    (busy),
    .par_err (par_err)
  );

  task automatic chk(input string nm,
                     input logic [31:0] act,
                     input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h",
               nm, act, exp);
    end
  endtask

  // Model: collect bits of a frame in a queue; when DW(+parity)
  // bits have arrived, assemble word LSB-first and even-parity.
  bit            m_on;
  bit            m_bits[$];
  logic [DW-1:0] m_out;
  bit            m_valid;
  bit            m_perr;

  always @(posedge clk or negedge rst) begin
    if (!rst) begin
      m_on = 1'b0;
      m_bits.delete();
      m_out = '0;
      m_valid = 1'b0;
      m_perr = 1'b0;
    end else begin
      m_valid = 1'b0;
      if (enb) begin
        if (!m_on && start) m_on = 1'b1;
        if (m_on) begin
          m_bits.push_back(inp);
          if (m_bits.size() == DW + PB) begin
            m_out = '0;
            m_perr = 1'b0;
            foreach (m_bits[i]) begin
              if (i < DW) m_out[i] = m_bits[i];
              m_perr ^= m_bits[i];
            end
            if (PB == 0) m_perr = 1'b0;
            m_valid = 1'b1;
            m_on = 1'b0;
            m_bits.delete();
          end
        end
      end
    end
  end

  always @(negedge clk) begin
    if (run && rst) begin
      chk("cyc_out", out, m_out);
      chk("cyc_valid", valid, m_valid);
      chk("cyc_busy", busy, m_on);
      chk("cyc_perr", par_err, m_perr);
    end
  end

  task automatic drive(input bit e, input bit s, input bit d);
    enb = e;
    start = s;
    inp = d;
    @(negedge clk);
    ncyc++;
  endtask

  task automatic frame(input logic [DW-1:0] w,
                       input bit p,
                       input int gap_at,
                       input int restart_at);
    for (int i = 0; i < DW; i++) begin
      if (i == gap_at) begin
        drive(1'b0, 1'b0, 1'b1);
        drive(1'b0, 1'b1, 1'b0);
      end
      drive(1'b1, (i == 0) || (i == restart_at), w[i]);
    end
    if (PB != 0) drive(1'b1, 1'b0, p);
  endtask

  int t0;

  initial begin
    repeat (2) @(negedge clk);
    chk("rst_out", out, 0);
    chk("rst_valid", valid, 0);
    chk("rst_busy", busy, 0);
    chk("rst_perr", par_err, 0);
    rst = 1'b1;
    run = 1'b1;
    drive(1'b0, 1'b0, 1'b0);

    // 0,1,0,1 -> 4'hA
    drive(1'b1, 1'b1, 1'b0);
    chk("a_busy_c2", busy, 1);
    chk("a_valid_c2", valid, 0);
    drive(1'b1, 1'b0, 1'b1);
    drive(1'b1, 1'b0, 1'b0);
    chk("a_valid_c4", valid, 0);
    drive(1'b1, 1'b0, 1'b1);
    if (PB != 0) drive(1'b1, 1'b0, 1'b0);
    chk("a_valid", valid, 1);
    chk("a_out", out, 4'hA);
    chk("a_busy", busy, 0);
    chk("a_perr", par_err, 0);
    drive(1'b0, 1'b0, 1'b0);
    chk("a_pulse", valid, 0);
    chk("a_hold", out, 4'hA);

    // enable gap between bits 1 and 2
    t0 = ncyc;
    frame(4'hA, 1'b0, 2, -1);
    chk("gap_len", ncyc - t0, DW + 2 + PB);
    chk("gap_valid", valid, 1);
    chk("gap_out", out, 4'hA);
    drive(1'b0, 1'b0, 1'b0);

    // back-to-back, second start on the valid cycle
    frame(4'h3, 1'b0, -1, -1);
    chk("b1_valid", valid, 1);
    chk("b1_out", out, 4'h3);
    t0 = ncyc;
    frame(4'hC, 1'b0, -1, -1);
    chk("b2_len", ncyc - t0, DW + PB);
    chk("b2_valid", valid, 1);
    chk("b2_out", out, 4'hC);
    drive(1'b0, 1'b0, 1'b0);

    // start reasserted on bit 2 is ignored
    frame(4'h5, 1'b0, -1, 2);
    chk("s_valid", valid, 1);
    chk("s_out", out, 4'h5);
    drive(1'b0, 1'b0, 1'b0);
    chk("s_idle", busy, 0);

    // reset after two bits
    drive(1'b1, 1'b1, 1'b1);
    drive(1'b1, 1'b0, 1'b1);
    chk("r_busy_pre", busy, 1);
    #2 rst = 1'b0;
    #1;
    chk("r_out", out, 0);
    chk("r_valid", valid, 0);
    chk("r_busy", busy, 0);
    @(negedge clk);
    rst = 1'b1;
    drive(1'b0, 1'b0, 1'b0);
    chk("r_quiet", valid, 0);
    frame(4'h9, 1'b0, -1, -1);
    chk("r9_valid", valid, 1);
    chk("r9_out", out, 4'h9);
    drive(1'b0, 1'b0, 1'b0);

`ifdef SIPO_PARITY_EN
    frame(4'hA, 1'b1, -1, -1);
    chk("p_valid", valid, 1);
    chk("p_out", out, 4'hA);
    chk("p_err", par_err, 1);
    drive(1'b0, 1'b0, 1'b0);
    chk("p_err_hold", par_err, 1);
    frame(4'hA, 1'b0, -1, -1);
    chk("p_ok", par_err, 0);
    drive(1'b0, 1'b0, 1'b0);
`endif

    repeat (2) drive(1'b0, 1'b0, 1'b0);
    $display("TB_RESULT checks=%0d failures=%0d",
             checks, failures);
    $finish;
  end

endmodule

// File: doc/sipo_lsb_rx.md
# sipo_lsb_rx

Serial-to-parallel receiver: the receiving end of the team's LSB-first PISO serial link. Detects a frame start, shifts in DW serial bits LSB first under clock enable, then presents the assembled word on a parallel bus with a one-cycle valid pulse. An optional even-parity bit can follow the data bits. It sits on the far side of the serial wire from the PISO transmitter, in the same clock domain.

## Interface
- DW, default 4: data word width in bits; legal range is DW >= 2.

- clk  input  1  clock; all state changes on the rising edge.
- rst  input  1  asynchronous reset, active low.
- enb  input  1  clock enable; a bit is sampled only on edges where enb=1.
- start  input  1  frame start; when high in IDLE with enb=1, the current inp value is bit 0.
- inp  input  1  serial data in, LSB first.
- out  output  DW  received word; holds its value until the next frame completes.
- valid  output  1  one-cycle pulse; out has just been updated.
- busy  output  1  high while a frame is in progress (state not IDLE).
- par_err  output  1  parity error flag for the word on out; tied 0 when parity is compiled out.

## Operation
- Reset (rst=0, asynchronous): state IDLE, bit counter 0, shift register 0, out=0, valid=0, busy=0, par_err=0.
- State machine:
  - IDLE:
    - enb=1 and start=1: shift inp in as bit 0, set count to 1, go to SHIFT.
    - Otherwise: stay in IDLE.
  - SHIFT:
    - enb=1: shift inp in and increment the count.
    - The edge that samples bit DW-1 (count = DW-1) ends the data phase. It goes to PARITY if parity is compiled in; otherwise it goes to IDLE and completes the frame.
    - enb=0: hold all state.
  - PARITY (compiled in only):
    - enb=1: sample the parity bit, go to IDLE and complete the frame.
    - enb=0: hold all state.
- Shift rule: the shift register shifts right and the new bit enters the MSB. After DW shifts, the first bit received is at position 0.
- Frame completion (registered, on the completing edge):
  - out receives the assembled word.
  - valid is set to 1.
  - par_err receives the parity result.
- valid clears on the next edge, regardless of enb.
- start is ignored in SHIFT and PARITY. A frame is never restarted mid-way.
- Back-to-back frames: start is accepted in IDLE on the cycle where valid=1, so there is no dead cycle between frames.
- Counter width is $clog2(DW); the counter never wraps because the frame ends at DW-1.

## Timing
- Bit sampling: one bit per edge with enb=1. The first bit is sampled on the edge with start=1.
- Latency without parity: valid is high in the cycle after the edge that sampled bit DW-1.
- Latency with parity: valid is high in the cycle after the edge that sampled the parity bit.
- With enb held at 1 the frame is DW cycles long, or DW+1 cycles with parity.
- busy goes high the cycle after start is accepted. It goes low in the same cycle that valid goes high.
- Reset mid-frame: the partial word is discarded. out returns to 0 and no valid pulse is produced.

## Configuration
- SIPO_PARITY_EN defined:
  - The PARITY state exists and an even-parity bit follows the DW data bits.
  - par_err = (XOR of the received data) XOR (parity bit), registered at frame completion.
  - par_err holds until the next frame completes.
- SIPO_PARITY_EN undefined:
  - There is no PARITY state; the frame completes on bit DW-1.
  - par_err is constant 0.

## Structure
- Package sipo_pkg holds:
  - state_e, an enum of IDLE, SHIFT and PARITY;
  - a counter width typedef derived from DW.
- Sub-module sipo_lsb is the datapath: an enable-gated right-shift register, DW wide, with serial input at the MSB.
- The top level holds the FSM, the bit counter, the output register and the parity logic.

## Test plan
All scenarios use DW=4.
- Single frame, parity compiled out, enb=1: start with inp bits 0,1,0,1 on four consecutive edges. Expect out=4'hA, valid high for exactly one cycle (the 5th cycle), and busy high for cycles 2-4.
- Enable gaps: same frame with enb=0 inserted for 2 cycles between bits 1 and 2. Expect out=4'hA, valid 2 cycles later than before, and state held during the gaps.
- Back-to-back frames: 4'h3 then 4'hC, with the second start on the valid cycle. Expect two valid pulses 4 cycles apart and out values 4'h3 then 4'hC.
- Start during a frame: assert start again on bit 2 of a 4'h5 frame. Expect it ignored and out=4'h5 after 4 samples.
- Reset mid-frame: drop rst after 2 bits. Expect out=0, valid=0 and busy=0 immediately. A following 4'h9 frame receives correctly.
- Parity, SIPO_PARITY_EN defined:
  - 4'hA with parity bit 0: expect par_err=0, valid after the 5th sample.
  - 4'hA with parity bit 1: expect par_err=1.
